gain_divider: RTL and testbench

- Inverse of the gain stage: attenuates or normalises a signed sample by dividing it by a programmable unsigned fixed-point divisor.
- Sits after gain or level-detect blocks to undo or trim applied gain.
- Uses a sequential restoring divider behind a valid/ready handshake.
- Output is saturated to the sample range.

---
 rtl/gain_pkg.sv | 10 +
 rtl/restoring_div_core.sv | 54 +++++
 rtl/gain_divider.sv | 74 +++++++
 tb/tb_gain_divider.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/gain_pkg.sv
// gain_pkg: shared width constants and FSM state type for the gain/divider blocks
package gain_pkg;
  localparam int GAIN_DATA_W = 8;
  localparam int GAIN_DIV_W = 8;
  localparam int GAIN_FRAC_BITS = 4;
  localparam int N = GAIN_DATA_W + GAIN_FRAC_BITS;
  localparam int SAT_POS = 2 ** (GAIN_DATA_W - 1) - 1;
  localparam int SAT_NEG = -(2 ** (GAIN_DATA_W - 1));
  typedef enum logic [1:0] {IDLE, DIV, FIX, OUT} state_t;
endpackage

// File: rtl/restoring_div_core.sv
// restoring_div_core: unsigned N-bit by DIV_W-bit restoring divider, one quotient bit per cycle
module restoring_div_core #(
  parameter int N = 12,
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [N-1:0]     i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_done,
  output logic [N-1:0]     o_quot
);
  localparam int CW = $clog2(N);
  localparam int RW = DIV_W + 1;
  logic [N-1:0] dvd_q;
  logic [RW-1:0] rem_q, rem_d;
  logic [RW:0] rem_sh;
  logic [DIV_W-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic busy_q, done_q, ge;
  always_comb begin
    rem_sh = {rem_q, dvd_q[N-1]};
    ge = rem_sh >= {2'b00, div_q};
    rem_d = ge ? RW'(rem_sh - {2'b00, div_q}) : rem_sh[RW-1:0];
  end
  // the dividend register shifts out numerator bits and shifts in quotient bits
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      dvd_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= busy_q && cnt_q == '0;
      if (i_start) begin
        dvd_q <= i_dividend;
        rem_q <= '0;
        div_q <= i_divisor;
        cnt_q <= CW'(N - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        dvd_q <= {dvd_q[N-2:0], ge};
        rem_q <= rem_d;
        cnt_q <= cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        busy_q <= cnt_q != '0;
      end
    end
  end
  assign o_done = done_q;
  assign o_quot = dvd_q;
endmodule

// File: rtl/gain_divider.sv
// gain_divider: signed sample / unsigned fixed-point divisor with saturation and valid/ready handshake
module gain_divider import gain_pkg::*; #(
  parameter int DATA_W = GAIN_DATA_W,
  parameter int DIV_W = GAIN_DIV_W,
  parameter int FRAC_BITS = GAIN_FRAC_BITS
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic [DIV_W-1:0]         i_div,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_sat,
  output logic                     o_div0
);
  localparam int NB = DATA_W + FRAC_BITS;
  localparam logic [NB-1:0] LIM_POS = NB'(2 ** (DATA_W - 1) - 1);
  localparam logic [NB-1:0] LIM_NEG = NB'(2 ** (DATA_W - 1));
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  state_t state_q, state_d;
  logic neg_q, zero_q, dz_q, sat_q, sat_d, div0_q, div0_d, accept, done;
  logic [DATA_W-1:0] data_q, data_d, mag;
  logic [NB-1:0] quot;
  assign accept = i_valid && o_ready;
  // magnitude kept unsigned so the most negative sample stays representable
  assign mag = i_data[DATA_W-1] ? -i_data : i_data;
  restoring_div_core #(.N(NB), .DIV_W(DIV_W)) u_core (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_start    (accept),
    .i_dividend ({mag, {FRAC_BITS{1'b0}}}),
    .i_divisor  (i_div == '0 ? DIV_W'(1) : i_div),
    .o_done     (done),
    .o_quot     (quot)
  );
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = i_valid ? DIV : IDLE;
      DIV: state_d = done ? FIX : DIV;
      FIX: state_d = OUT;
      OUT: state_d = i_ready ? IDLE : OUT;
    endcase
  end
  always_comb begin
    o_ready = state_q == IDLE;
    o_valid = state_q == OUT;
  end
  always_comb begin
    sat_d = dz_q ? !zero_q : (neg_q ? quot > LIM_NEG : quot > LIM_POS);
    data_d = sat_d ? (neg_q ? MIN_V : MAX_V) : dz_q ? '0 : neg_q ? -quot[DATA_W-1:0] : quot[DATA_W-1:0];
    div0_d = dz_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      {neg_q, zero_q, dz_q} <= '0;
      {data_q, sat_q, div0_q} <= '0;
    end else begin
      if (accept) {neg_q, zero_q, dz_q} <= {i_data[DATA_W-1], i_data == '0, i_div == '0};
      if (state_q == FIX) {data_q, sat_q, div0_q} <= {data_d, sat_d, div0_d};
    end
  end
  assign o_data = data_q;
  assign o_sat = sat_q;
  assign o_div0 = div0_q;
endmodule

// File: tb/tb_gain_divider.sv
// tb_gain_divider: directed vectors against an arithmetic reference model with a per-cycle scoreboard
module tb_gain_divider;
  logic clk = 1'b0, rst_n = 1'b0;
  logic signed [7:0] i_data = '0;
  logic [7:0] i_div = '0;
  logic i_valid = 1'b0, i_ready = 1'b0;
  logic o_ready, o_valid, o_sat, o_div0;
  logic signed [7:0] o_data;
  always #5 clk = ~clk;
  gain_divider dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(i_data), .i_div(i_div), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_sat(o_sat), .o_div0(o_div0)
  );
  typedef struct {logic [9:0] exp; int acc;} item_t;
  item_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  bit busy = 0, rst_pend = 0, prev_valid = 0, timed_out = 0;
  // expected {o_data, o_sat, o_div0} from plain integer division (truncates toward zero)
  function automatic logic [9:0] model(input int d, input int v);
    int q;
    logic [7:0] r;
    if (v == 0) begin
      r = d > 0 ? 8'd127 : (d < 0 ? 8'h80 : 8'h00);
      return {r, d != 0, 1'b1};
    end
    q = d * 16 / v;
    if (q > 127) return {8'd127, 2'b10};
    if (q < -128) return {8'h80, 2'b10};
    r = 8'(q);
    return {r, 2'b00};
  endfunction
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (cyc == 1) begin
      chk("pin_100_div2", model(100, 32), {8'd50, 2'b00});
      chk("pin_m100_div3", model(-100, 48), {8'hDF, 2'b00});
      chk("pin_100_div0p5", model(100, 8), {8'd127, 2'b10});
      chk("pin_m128_div1", model(-128, 16), {8'h80, 2'b00});
      chk("pin_5_div0", model(5, 0), {8'd127, 2'b11});
      chk("pin_m5_div0", model(-5, 0), {8'h80, 2'b11});
      chk("pin_0_div0", model(0, 0), {8'h00, 2'b01});
    end
    if (rst_pend) begin
      chk("reset_state", {o_valid, o_ready, o_data}, {1'b0, 1'b1, 8'h00});
      rst_pend = 0;
    end else begin
      chk("ready", o_ready, !busy);
      if (o_valid) begin
        if (sb.size() == 0) chk("unexpected_valid", o_valid, 0);
        else begin
          chk("result", {o_data, o_sat, o_div0}, sb[0].exp);
          if (!prev_valid) chk("latency", cyc - sb[0].acc, 15);
        end
      end else if (busy && sb.size() > 0 && cyc - sb[0].acc > 15 && !timed_out) begin
        chk("valid_timeout", o_valid, 1);
        timed_out = 1;
      end
    end
    prev_valid = o_valid;
    if (!rst_n) begin
      sb.delete();
      busy = 0;
      rst_pend = 1;
    end else begin
      if (i_valid && !busy) begin
        sb.push_back('{exp: model(int'(i_data), int'(i_div)), acc: cyc});
        busy = 1;
      end else if (o_valid && i_ready && sb.size() > 0) begin
        void'(sb.pop_front());
        busy = 0;
        timed_out = 0;
      end
    end
  end
  task automatic send(input logic signed [7:0] d, input logic [7:0] v, input bit now);
    bit r;
    if (!now) @(posedge clk);
    #1 i_data = d; i_div = v; i_valid = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      if (k == 100) begin
        $display("FAIL send_timeout: o_ready never seen");
        $fatal(1, "input never accepted");
      end
      @(negedge clk);
      r = o_ready;
      @(posedge clk);
      if (r) break;
    end
    #1 i_valid = 1'b0; i_data = 8'($urandom); i_div = 8'($urandom);
  endtask
  task automatic recv(input int hold);
    for (int k = 0; k <= 100; k++) begin
      if (k == 100) begin
        $display("FAIL recv_timeout: o_valid never seen");
        $fatal(1, "output never valid");
      end
      @(negedge clk);
      if (o_valid) break;
    end
    repeat (hold) begin
      @(posedge clk);
      #1 i_valid = ~i_valid; i_data = 8'($urandom); i_div = 8'($urandom);
    end
    @(posedge clk);
    #1 i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
  endtask
  int dv[7] = '{100, -100, 100, -128, 5, -5, 0};
  int vv[7] = '{32, 48, 8, 16, 0, 0, 0};
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(8'(dv[i]), 8'(vv[i]), 1'b0);
      recv(0);
    end
    send(8'sd37, 8'h18, 1'b0);
    recv(5);
    send(-8'sd77, 8'h11, 1'b1);
    recv(0);
    send(8'sd90, 8'h10, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'sd60, 8'h10, 1'b0);
    recv(0);
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
